// File: rtl/safe_pkg.sv
// Shared types for the lockstep safe-mode sync initiator.
package safe_pkg;

  localparam int SAFE_IRQ_ID_W = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    HALT_WAIT = 3'd2,
    SYNC2     = 3'd3,
    IRQ       = 3'd4,
    ACK       = 3'd5,
    DONE      = 3'd6
  } safe_sync_state_e;

endpackage

// File: rtl/safe_stable_counter.sv
// Saturating up-counter with synchronous clear and enable.
// done_o is high while the count sits at TERM; the count never passes TERM.
module safe_stable_counter #(
  parameter int TERM = 3,
  parameter int W    = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [W-1:0] TERM_C = W'(TERM);

  logic [W-1:0] cnt_q;

  // Count enabled cycles, hold at TERM, clear has priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != TERM_C)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign done_o = (cnt_q == TERM_C);

endmodule

// File: rtl/safe_sync_initiator.sv
// Core-side sync initiator for the lockstep safe-mode controller.
// Sequences sync1 -> shadow halt -> sync2 -> master irq -> ack -> single-bus done.
// Optional build macro SAFE_SYNC_TIMEOUT_EN adds a per-state timeout on the
// four wait states (REQ, HALT_WAIT, SYNC2, IRQ) that aborts back to IDLE.
//
// state     | meaning
// IDLE      | waiting for a sync request from the master core
// REQ       | sync1 raised, waiting for the controller halt phase
// HALT_WAIT | shadow halt requested, waiting for a stable halted status
// SYNC2     | shadow halted and stable, waiting for the sync-irq phase
// IRQ       | sync interrupt raised to master, waiting for matching ack
// ACK       | one-cycle ack pulse to the controller
// DONE      | holding the shadow halted while single-bus mode is active
module safe_sync_initiator
  import safe_pkg::*;
#(
  parameter int                         HALT_STABLE_CYCLES = 4,
  parameter int                         TIMEOUT_CYCLES     = 1024,
  parameter logic [SAFE_IRQ_ID_W-1:0]   IRQ_ID             = 5'd31
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     sync_req_i,
  input  logic                     shadow_halted_i,
  input  logic                     interrupt_halt_i,
  input  logic                     interrupt_sync_i,
  input  logic                     single_bus_i,
  input  logic                     irq_ack_i,
  input  logic [SAFE_IRQ_ID_W-1:0] irq_id_i,
  output logic                     sync1_o,
  output logic                     sync2_o,
  output logic                     intc_ack_o,
  output logic                     shadow_halt_req_o,
  output logic                     master_irq_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int STABLE_W = $clog2(HALT_STABLE_CYCLES + 1);

  safe_sync_state_e state_q, state_d;
  logic state_change;
  logic stable_done;
  logic timeout_hit;
  logic timeout_fire;

  logic sync1_d, sync2_d, intc_ack_d, halt_req_d, irq_d, busy_d, timeout_d;

  assign state_change = (state_d != state_q);

  // Counts consecutive halted cycles; a low halted status restarts the window.
  safe_stable_counter #(
    .TERM (HALT_STABLE_CYCLES - 1),
    .W    (STABLE_W)
  ) u_stable_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_change || !shadow_halted_i),
    .en_i   ((state_q == HALT_WAIT) && shadow_halted_i),
    .done_o (stable_done)
  );

`ifdef SAFE_SYNC_TIMEOUT_EN
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic in_wait;
  logic timeout_done;

  assign in_wait = (state_q == REQ) || (state_q == HALT_WAIT) ||
                   (state_q == SYNC2) || (state_q == IRQ);

  safe_stable_counter #(
    .TERM (TIMEOUT_CYCLES - 1),
    .W    (TIMEOUT_W)
  ) u_timeout_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_change),
    .en_i   (in_wait),
    .done_o (timeout_done)
  );

  assign timeout_hit = in_wait && timeout_done;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a legitimate handshake step wins over a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_req_i) state_d = REQ;
      end
      REQ: begin
        if (interrupt_halt_i) begin
          state_d = HALT_WAIT;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          timeout_fire = 1'b1;
        end
      end
      HALT_WAIT: begin
        if (shadow_halted_i && stable_done) begin
          state_d = SYNC2;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          timeout_fire = 1'b1;
        end
      end
      SYNC2: begin
        if (interrupt_sync_i) begin
          state_d = IRQ;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          timeout_fire = 1'b1;
        end
      end
      IRQ: begin
        if (irq_ack_i && (irq_id_i == IRQ_ID)) begin
          state_d = ACK;
        end else if (timeout_hit) begin
          state_d      = IDLE;
          timeout_fire = 1'b1;
        end
      end
      ACK: begin
        state_d = DONE;
      end
      DONE: begin
        if (!single_bus_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with state_q.
  always_comb begin
    sync1_d    = (state_d == REQ);
    sync2_d    = (state_d == SYNC2);
    intc_ack_d = (state_d == ACK);
    irq_d      = (state_d == IRQ);
    halt_req_d = (state_d == HALT_WAIT) || (state_d == SYNC2) ||
                 (state_d == IRQ) || (state_d == ACK) || (state_d == DONE);
    busy_d     = (state_d != IDLE);
    timeout_d  = timeout_fire;
  end

  // Output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_o           <= 1'b0;
      sync2_o           <= 1'b0;
      intc_ack_o        <= 1'b0;
      shadow_halt_req_o <= 1'b0;
      master_irq_o      <= 1'b0;
      busy_o            <= 1'b0;
      timeout_o         <= 1'b0;
    end else begin
      sync1_o           <= sync1_d;
      sync2_o           <= sync2_d;
      intc_ack_o        <= intc_ack_d;
      shadow_halt_req_o <= halt_req_d;
      master_irq_o      <= irq_d;
      busy_o            <= busy_d;
      timeout_o         <= timeout_d;
    end
  end

endmodule

// File: tb/tb_safe_sync_initiator.sv
// Directed bench for safe_sync_initiator (HALT_STABLE_CYCLES=4, TIMEOUT_CYCLES=16).
// Output vector order: {sync1, sync2, intc_ack, halt_req, master_irq, busy, timeout}.
// Input vector order:  {sync_req, shadow_halted, interrupt_halt, interrupt_sync, single_bus, irq_ack}.
module tb_safe_sync_initiator;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       sync_req_i, shadow_halted_i, interrupt_halt_i, interrupt_sync_i;
  logic       single_bus_i, irq_ack_i;
  logic [4:0] irq_id_i;
  logic       sync1_o, sync2_o, intc_ack_o, shadow_halt_req_o, master_irq_o, busy_o, timeout_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] in_bits;
    logic [4:0] id;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  safe_sync_initiator #(
    .HALT_STABLE_CYCLES (4),
    .TIMEOUT_CYCLES     (16),
    .IRQ_ID             (5'd31)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .sync_req_i        (sync_req_i),
    .shadow_halted_i   (shadow_halted_i),
    .interrupt_halt_i  (interrupt_halt_i),
    .interrupt_sync_i  (interrupt_sync_i),
    .single_bus_i      (single_bus_i),
    .irq_ack_i         (irq_ack_i),
    .irq_id_i          (irq_id_i),
    .sync1_o           (sync1_o),
    .sync2_o           (sync2_o),
    .intc_ack_o        (intc_ack_o),
    .shadow_halt_req_o (shadow_halt_req_o),
    .master_irq_o      (master_irq_o),
    .busy_o            (busy_o),
    .timeout_o         (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [6:0] outs();
    return {sync1_o, sync2_o, intc_ack_o, shadow_halt_req_o, master_irq_o, busy_o, timeout_o};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] b, input logic [4:0] id);
    {sync_req_i, shadow_halted_i, interrupt_halt_i, interrupt_sync_i, single_bus_i, irq_ack_i} = b;
    irq_id_i = id;
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [5:0] b, input logic [4:0] id);
    drive(b, id);
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input logic [5:0] b, input logic [4:0] id, input logic [6:0] e);
    vec_t v;
    v.in_bits = b;
    v.id      = id;
    v.exp     = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fire_k;
    logic sync2_held;

    // Nominal flow plus wrong-id ack.
    add(6'b000000, 5'd0,  7'b0000000);
    add(6'b100000, 5'd0,  7'b1000010);
    add(6'b000000, 5'd0,  7'b1000010);
    add(6'b001000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0101010);
    add(6'b011010, 5'd0,  7'b0101010);
    add(6'b011110, 5'd0,  7'b0001110);
    add(6'b011011, 5'd7,  7'b0001110);
    add(6'b011011, 5'd31, 7'b0011010);
    add(6'b010010, 5'd0,  7'b0001010);
    add(6'b000010, 5'd0,  7'b0001010);
    add(6'b000000, 5'd0,  7'b0000000);
    add(6'b000000, 5'd0,  7'b0000000);
    // Glitchy halt 1,1,0,1,1,1,1 with an ignored extra sync request.
    add(6'b100000, 5'd0,  7'b1000010);
    add(6'b001000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b001000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b111000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0101010);
    add(6'b000100, 5'd0,  7'b0001110);
    add(6'b000001, 5'd31, 7'b0011010);
    add(6'b000000, 5'd0,  7'b0001010);
    add(6'b000000, 5'd0,  7'b0000000);
    // Early halt: sync1 for exactly one cycle, then into SYNC2.
    add(6'b101000, 5'd0,  7'b1000010);
    add(6'b001000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0001010);
    add(6'b011000, 5'd0,  7'b0101010);

    rst_ni = 1'b0;
    drive(6'b000000, 5'd0);
    #1;
    check("reset_outputs", outs(), 7'b0000000);
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].in_bits, vecs[i].id);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset while in SYNC2 with stale inputs present.
    rst_ni = 1'b0;
    drive(6'b011111, 5'd31);
    #1;
    check("reset_async", outs(), 7'b0000000);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(6'b011111, 5'd31);
      check($sformatf("stale_idle%0d", i), outs(), 7'b0000000);
    end

    // Walk into SYNC2 and never raise interrupt_sync_i.
    step(6'b101010, 5'd0);
    check("to_req", outs(), 7'b1000010);
    step(6'b011010, 5'd0);
    check("to_halt_wait", outs(), 7'b0001010);
    for (int i = 0; i < 3; i++) step(6'b011010, 5'd0);
    step(6'b011010, 5'd0);
    check("to_sync2", outs(), 7'b0101010);

    fire_k     = 0;
    sync2_held = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(6'b011010, 5'd0);
      if (timeout_o === 1'b1) begin
        fire_k = k;
        break;
      end
      if (sync2_o !== 1'b1) sync2_held = 1'b0;
    end
    check("sync2_held_before_timeout", {6'b0, sync2_held}, 7'b0000001);
`ifdef SAFE_SYNC_TIMEOUT_EN
    check("timeout_cycle", 7'(fire_k), 7'd16);
    check("timeout_outputs", outs(), 7'b0000001);
    step(6'b011010, 5'd0);
    check("timeout_single_pulse", outs(), 7'b0000000);
`else
    check("no_timeout", 7'(fire_k), 7'd0);
    check("still_sync2", outs(), 7'b0101010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
